nco_mixer_cic: RTL and testbench
================================

Name: nco_mixer_cic

Overview:
- Downstream consumer of the NCO square-wave outputs.
- Mixes the 1-bit comparator RF sample with the NCO sine and cosine bits to form I/Q products.
- Each I/Q product is low-pass filtered and decimated by a 3rd-order CIC filter (differential delay 1).
- Produces saturated signed baseband I/Q words with a single-cycle valid strobe for the demodulator.

Parameters:
- DECIMATION, 4096, decimation ratio R, ≥4.
- ACC_WIDTH, 40, integrator/comb register width; must be ≥ 2 + 3*ceil(log2(R)).
- OUT_SHIFT, 25, LSB index of the comb result taken for output.
- OUT_WIDTH, 12, output word width (signed).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- rf_in  input  1  1-bit RF sample (1 = +1, 0 = -1).
- sinewave_in  input  1  NCO sine bit (1 = +1, 0 = -1).
- cosinewave_in  input  1  NCO cosine bit (1 = +1, 0 = -1).
- i_out  output  OUT_WIDTH  signed I sample.
- q_out  output  OUT_WIDTH  signed Q sample.
- out_valid  output  1  one-cycle strobe, i_out/q_out valid.

Behaviour:
- Reset: every register clears on a clk edge with rst_n=0, i.e. integrators, comb delays, dec_cnt, warm-up counter, comb sequencer, i_out=0, q_out=0, out_valid=0. Reset takes priority over all other activity.
- Cycle numbering: cycle 0 is the first cycle with rst_n=1.
- Mixer (combinational):
  - i_bit = rf_in XNOR cosinewave_in.
  - q_bit = rf_in XNOR sinewave_in.
  - Each product maps to x = +1 when the bit is 1 and -1 when it is 0, sign-extended to ACC_WIDTH.
- Integrators, every cycle, per channel, registered chain using previous-cycle values:
  - int1 <= int1 + x
  - int2 <= int2 + int1
  - int3 <= int3 + int2
  - All arithmetic is two's complement modulo 2^ACC_WIDTH. Wrap-around is required and must not be detected or saturated.
- Decimation counter:
  - dec_cnt counts 0..DECIMATION-1 and wraps to 0.
  - A strobe cycle is any cycle with dec_cnt==DECIMATION-1 (cycles 3, 7, 11… for R=4).
  - On the strobe edge, the pre-update int3 of each channel is captured into comb_in.
- Comb sequencer, states IDLE → C1 → C2 → C3 → IDLE, one stage per cycle:
  - C1: y1 = comb_in - d1; d1 <= comb_in.
  - C2: y2 = y1 - d2; d2 <= y1.
  - C3: y3 = y2 - d3; d3 <= y2; the output register loads.
  - All comb arithmetic is modulo 2^ACC_WIDTH.
  - The sequencer always completes within 3 cycles, well before the next strobe (R≥4), so it never overruns.
- Output scaling:
  - v = y3 arithmetically shifted right by OUT_SHIFT (truncation toward -inf).
  - v saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - I and Q are scaled identically.
- Latency: out_valid is high exactly in cycle strobe+4, with i_out/q_out updated in the same cycle. i_out/q_out hold their values between strobes.
- Warm-up:
  - The first 3 comb results after reset (zero-initialised delays) are discarded: out_valid stays 0 and i_out/q_out stay 0.
  - With R=4, the first out_valid is in cycle 19, then at 23, 27, …
- Reset mid-operation: a sequencer in C1–C3 is abandoned, no out_valid is produced, and the warm-up count restarts from 0.
- Steady-state gain for a constant input x is R^3*x before shift/saturation.

Test Plan:
All scenarios use R=4, ACC_WIDTH=10, OUT_SHIFT=0 unless stated.

1. Constant +1 (rf_in=1, sin=1, cos=1), OUT_WIDTH=8, from reset → out_valid only at cycles 19, 23, 27…; i_out=q_out=64 on each; no out_valid at cycles 7, 11, 15.
2. I/Q separation: rf_in=1, cos=1, sin=0 constant, OUT_WIDTH=8 → i_out=64, q_out=-64 from cycle 19 onward.
3. Saturation: as scenario 2 with OUT_WIDTH=6 → i_out=31, q_out=-32; second pass with OUT_WIDTH=8, OUT_SHIFT=3 → i_out=8, q_out=-8.
4. Integrator wrap: ACC_WIDTH=8, constant +1, run 200 cycles → i_out stays 64 on every valid strobe despite int3 wrapping.
5. Reset mid-operation: constant +1; assert rst_n=0 for 1 cycle at cycle 20 (sequencer active) → no out_valid at 23; outputs clear to 0; first out_valid is 19 cycles after reset release, value 64.
6. Alternating input: rf_in toggles each cycle, cos=1, sin=1, OUT_WIDTH=8 → i_out=q_out=0 after warm-up (DC rejection), out_valid period exactly 4 cycles.

Source files
------------

// File: rtl/nco_mixer_cic.sv
// 1-bit RF x NCO I/Q mixer feeding one 3rd-order CIC decimator per channel.
// The three comb stages are time-multiplexed over the three cycles following each decimation strobe.
module nco_mixer_cic #(
    parameter int DECIMATION = 4096,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_SHIFT  = 25,
    parameter int OUT_WIDTH  = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rf_in,
    input  logic                        sinewave_in,
    input  logic                        cosinewave_in,
    output logic signed [OUT_WIDTH-1:0] i_out,
    output logic signed [OUT_WIDTH-1:0] q_out,
    output logic                        out_valid
);
    localparam int NCH   = 2;
    localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DECIMATION - 1);
    localparam logic [1:0]       WARM_DONE = 2'd3;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE,
        C1,
        C2,
        C3
    } seq_state_t;

    seq_state_t state_reg, state_next;
    logic c1_en, c2_en, c3_en;

    logic [CNT_W-1:0] dec_cnt_reg;
    logic             strobe;
    logic [1:0]       warm_cnt_reg;

    // Channel 0 is I (cosine), channel 1 is Q (sine).
    logic [NCH-1:0]                mix_bit;
    logic [NCH-1:0][OUT_WIDTH-1:0] sat_val;

    assign mix_bit[0] = ~(rf_in ^ cosinewave_in);
    assign mix_bit[1] = ~(rf_in ^ sinewave_in);
    assign strobe     = (dec_cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt_reg <= '0;
        end else if (strobe) begin
            dec_cnt_reg <= '0;
        end else begin
            dec_cnt_reg <= dec_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        c1_en      = 1'b0;
        c2_en      = 1'b0;
        c3_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (strobe) begin
                    state_next = C1;
                end
            end
            C1: begin
                c1_en      = 1'b1;
                state_next = C2;
            end
            C2: begin
                c2_en      = 1'b1;
                state_next = C3;
            end
            C3: begin
                c3_en      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [ACC_WIDTH-1:0]        x;
            logic [ACC_WIDTH-1:0]        int1_reg, int2_reg, int3_reg;
            logic [ACC_WIDTH-1:0]        comb_in_reg;
            logic [ACC_WIDTH-1:0]        d1_reg, d2_reg, d3_reg;
            logic [ACC_WIDTH-1:0]        y1_reg, y2_reg;
            logic [ACC_WIDTH-1:0]        y3;
            logic signed [ACC_WIDTH-1:0] scaled;
            logic [OUT_WIDTH-1:0]        sat;

            assign x = mix_bit[gi] ? ACC_WIDTH'(1) : {ACC_WIDTH{1'b1}};

            // Integrators wrap freely; the comb differences cancel the wrap.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    int1_reg <= '0;
                    int2_reg <= '0;
                    int3_reg <= '0;
                end else begin
                    int1_reg <= int1_reg + x;
                    int2_reg <= int2_reg + int1_reg;
                    int3_reg <= int3_reg + int2_reg;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    comb_in_reg <= '0;
                    d1_reg      <= '0;
                    d2_reg      <= '0;
                    d3_reg      <= '0;
                    y1_reg      <= '0;
                    y2_reg      <= '0;
                end else begin
                    if (strobe) begin
                        comb_in_reg <= int3_reg;
                    end
                    if (c1_en) begin
                        y1_reg <= comb_in_reg - d1_reg;
                        d1_reg <= comb_in_reg;
                    end
                    if (c2_en) begin
                        y2_reg <= y1_reg - d2_reg;
                        d2_reg <= y1_reg;
                    end
                    if (c3_en) begin
                        d3_reg <= y2_reg;
                    end
                end
            end

            assign y3     = y2_reg - d3_reg;
            assign scaled = $signed(y3) >>> OUT_SHIFT;

            always_comb begin
                sat = scaled[OUT_WIDTH-1:0];
                if (scaled > SAT_MAX) begin
                    sat = SAT_MAX[OUT_WIDTH-1:0];
                end else if (scaled < SAT_MIN) begin
                    sat = SAT_MIN[OUT_WIDTH-1:0];
                end
            end

            assign sat_val[gi] = sat;
        end
    endgenerate

    // The first three comb results come from zeroed delay lines and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_cnt_reg <= '0;
            i_out        <= '0;
            q_out        <= '0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (c3_en) begin
                if (warm_cnt_reg == WARM_DONE) begin
                    i_out     <= sat_val[0];
                    q_out     <= sat_val[1];
                    out_valid <= 1'b1;
                end else begin
                    warm_cnt_reg <= warm_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nco_mixer_cic.sv
// Bench for nco_mixer_cic: four parameterisations share one stimulus stream; expected samples
// are queued at each emitting decimation strobe and consumed in the cycle out_valid is due.
`timescale 1ns/1ps
module tb_nco_mixer_cic;
    localparam int R           = 4;
    localparam int GAIN        = R * R * R;
    localparam int WARM_STROBE = 4 * R - 1;
    localparam int LATENCY     = 4;

    logic clk           = 1'b0;
    logic rst_n         = 1'b0;
    logic rf_in         = 1'b0;
    logic sinewave_in   = 1'b0;
    logic cosinewave_in = 1'b0;

    logic signed [7:0] a_i, a_q, w_i, w_q, h_i, h_q;
    logic signed [5:0] s_i, s_q;
    logic              a_v, w_v, s_v, h_v;

    always #5 clk = ~clk;

    nco_mixer_cic #(.DECIMATION(R), .ACC_WIDTH(10), .OUT_SHIFT(0), .OUT_WIDTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .rf_in(rf_in), .sinewave_in(sinewave_in),
        .cosinewave_in(cosinewave_in), .i_out(a_i), .q_out(a_q), .out_valid(a_v));

    nco_mixer_cic #(.DECIMATION(R), .ACC_WIDTH(8), .OUT_SHIFT(0), .OUT_WIDTH(8)) u_w (
        .clk(clk), .rst_n(rst_n), .rf_in(rf_in), .sinewave_in(sinewave_in),
        .cosinewave_in(cosinewave_in), .i_out(w_i), .q_out(w_q), .out_valid(w_v));

    nco_mixer_cic #(.DECIMATION(R), .ACC_WIDTH(10), .OUT_SHIFT(0), .OUT_WIDTH(6)) u_s (
        .clk(clk), .rst_n(rst_n), .rf_in(rf_in), .sinewave_in(sinewave_in),
        .cosinewave_in(cosinewave_in), .i_out(s_i), .q_out(s_q), .out_valid(s_v));

    nco_mixer_cic #(.DECIMATION(R), .ACC_WIDTH(10), .OUT_SHIFT(3), .OUT_WIDTH(8)) u_h (
        .clk(clk), .rst_n(rst_n), .rf_in(rf_in), .sinewave_in(sinewave_in),
        .cosinewave_in(cosinewave_in), .i_out(h_i), .q_out(h_q), .out_valid(h_v));

    typedef struct {
        int due;
        int gi;
        int gq;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   passed;
    int   total;

    function automatic int scale(input int y, input int sh, input int w);
        int v;
        int hi;
        int lo;
        v  = y >>> sh;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Mode 0: constant +1 on both channels; 1: I=+1, Q=-1; other: rf toggles every cycle.
    task automatic drive_cycle(input int mode);
        exp_t e;
        case (mode)
            0: begin
                rf_in = 1'b1; sinewave_in = 1'b1; cosinewave_in = 1'b1;
                e.gi = GAIN; e.gq = GAIN;
            end
            1: begin
                rf_in = 1'b1; sinewave_in = 1'b0; cosinewave_in = 1'b1;
                e.gi = GAIN; e.gq = -GAIN;
            end
            default: begin
                rf_in = (cyc % 2 == 0); sinewave_in = 1'b1; cosinewave_in = 1'b1;
                e.gi = 0; e.gq = 0;
            end
        endcase
        if ((cyc % R == R - 1) && (cyc >= WARM_STROBE)) begin
            e.due = cyc + LATENCY;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sb.delete();
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset(3);
        total++; if (a_v !== 1'b0) $display("FAIL reset_a_valid got=%b exp=0", a_v); else passed++;
        total++; if (a_i !== 0) $display("FAIL reset_a_i got=%0d exp=0", a_i); else passed++;
        total++; if (a_q !== 0) $display("FAIL reset_a_q got=%0d exp=0", a_q); else passed++;
        total++; if (w_v !== 1'b0) $display("FAIL reset_w_valid got=%b exp=0", w_v); else passed++;
        total++; if (w_i !== 0) $display("FAIL reset_w_i got=%0d exp=0", w_i); else passed++;
        total++; if (s_v !== 1'b0) $display("FAIL reset_s_valid got=%b exp=0", s_v); else passed++;
        total++; if (s_q !== 0) $display("FAIL reset_s_q got=%0d exp=0", s_q); else passed++;
        total++; if (h_i !== 0) $display("FAIL reset_h_i got=%0d exp=0", h_i); else passed++;
        $display("reset cyc=%0d valid=%b i=%0d q=%0d", cyc, a_v, a_i, a_q);
    endtask

    // Constant +1 on the main instance and on the 8-bit accumulator instance that wraps.
    task automatic test_constant();
        int   hold_i;
        int   hold_q;
        int   nvalid;
        bit   ev;
        exp_t e;
        do_reset(2);
        hold_i = 0; hold_q = 0; nvalid = 0;
        for (int n = 0; n < 200; n++) begin
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            total++; if (a_v !== ev) $display("FAIL const_valid cyc=%0d got=%b exp=%b", cyc, a_v, ev); else passed++;
            total++; if (w_v !== ev) $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, w_v, ev); else passed++;
            if (ev) begin
                e      = sb.pop_front();
                hold_i = scale(e.gi, 0, 8);
                hold_q = scale(e.gq, 0, 8);
                nvalid++;
                $display("const cyc=%0d i=%0d q=%0d wrap_i=%0d wrap_q=%0d", cyc, a_i, a_q, w_i, w_q);
            end
            total++; if (a_i !== hold_i) $display("FAIL const_i cyc=%0d got=%0d exp=%0d", cyc, a_i, hold_i); else passed++;
            total++; if (a_q !== hold_q) $display("FAIL const_q cyc=%0d got=%0d exp=%0d", cyc, a_q, hold_q); else passed++;
            total++; if (w_i !== hold_i) $display("FAIL wrap_i cyc=%0d got=%0d exp=%0d", cyc, w_i, hold_i); else passed++;
            total++; if (w_q !== hold_q) $display("FAIL wrap_q cyc=%0d got=%0d exp=%0d", cyc, w_q, hold_q); else passed++;
            drive_cycle(0);
        end
        total++; if (nvalid !== 46) $display("FAIL const_count got=%0d exp=46", nvalid); else passed++;
    endtask

    // I/Q separation, output saturation and output shift.
    task automatic test_iq_separation();
        int   ai, aq, si, sq, hi, hq;
        bit   ev;
        exp_t e;
        do_reset(2);
        ai = 0; aq = 0; si = 0; sq = 0; hi = 0; hq = 0;
        for (int n = 0; n < 40; n++) begin
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            total++; if (a_v !== ev) $display("FAIL iq_valid cyc=%0d got=%b exp=%b", cyc, a_v, ev); else passed++;
            total++; if (s_v !== ev) $display("FAIL sat_valid cyc=%0d got=%b exp=%b", cyc, s_v, ev); else passed++;
            total++; if (h_v !== ev) $display("FAIL shift_valid cyc=%0d got=%b exp=%b", cyc, h_v, ev); else passed++;
            if (ev) begin
                e  = sb.pop_front();
                ai = scale(e.gi, 0, 8); aq = scale(e.gq, 0, 8);
                si = scale(e.gi, 0, 6); sq = scale(e.gq, 0, 6);
                hi = scale(e.gi, 3, 8); hq = scale(e.gq, 3, 8);
                $display("iq cyc=%0d i=%0d q=%0d sat_i=%0d sat_q=%0d shift_i=%0d shift_q=%0d",
                         cyc, a_i, a_q, s_i, s_q, h_i, h_q);
            end
            total++; if (a_i !== ai) $display("FAIL iq_i cyc=%0d got=%0d exp=%0d", cyc, a_i, ai); else passed++;
            total++; if (a_q !== aq) $display("FAIL iq_q cyc=%0d got=%0d exp=%0d", cyc, a_q, aq); else passed++;
            total++; if (s_i !== si) $display("FAIL sat_i cyc=%0d got=%0d exp=%0d", cyc, s_i, si); else passed++;
            total++; if (s_q !== sq) $display("FAIL sat_q cyc=%0d got=%0d exp=%0d", cyc, s_q, sq); else passed++;
            total++; if (h_i !== hi) $display("FAIL shift_i cyc=%0d got=%0d exp=%0d", cyc, h_i, hi); else passed++;
            total++; if (h_q !== hq) $display("FAIL shift_q cyc=%0d got=%0d exp=%0d", cyc, h_q, hq); else passed++;
            drive_cycle(1);
        end
    endtask

    // One-cycle reset at cycle 20 while the sequencer works on the cycle-19 strobe.
    task automatic test_reset_mid();
        int   hold;
        int   first;
        bit   ev;
        exp_t e;
        do_reset(2);
        hold = 0;
        for (int n = 0; n < 20; n++) begin
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            total++; if (a_v !== ev) $display("FAIL mid_pre_valid cyc=%0d got=%b exp=%b", cyc, a_v, ev); else passed++;
            if (ev) begin
                e    = sb.pop_front();
                hold = scale(e.gi, 0, 8);
            end
            total++; if (a_i !== hold) $display("FAIL mid_pre_i cyc=%0d got=%0d exp=%0d", cyc, a_i, hold); else passed++;
            drive_cycle(0);
        end
        total++; if (a_v !== 1'b0) $display("FAIL mid_c1_valid cyc=%0d got=%b exp=0", cyc, a_v); else passed++;
        do_reset(1);
        hold  = 0;
        first = -1;
        for (int n = 0; n < 30; n++) begin
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            total++; if (a_v !== ev) $display("FAIL mid_post_valid cyc=%0d got=%b exp=%b", cyc, a_v, ev); else passed++;
            if (a_v === 1'b1 && first < 0) first = cyc;
            if (ev) begin
                e    = sb.pop_front();
                hold = scale(e.gi, 0, 8);
                $display("mid cyc=%0d i=%0d q=%0d", cyc, a_i, a_q);
            end
            total++; if (a_i !== hold) $display("FAIL mid_post_i cyc=%0d got=%0d exp=%0d", cyc, a_i, hold); else passed++;
            total++; if (a_q !== hold) $display("FAIL mid_post_q cyc=%0d got=%0d exp=%0d", cyc, a_q, hold); else passed++;
            drive_cycle(0);
        end
        total++; if (first !== 19) $display("FAIL mid_first_valid got=%0d exp=19", first); else passed++;
    endtask

    // Alternating rf: DC rejected to zero, strobes exactly R cycles apart.
    task automatic test_alternating();
        int   last;
        bit   ev;
        exp_t e;
        do_reset(2);
        last = -1;
        for (int n = 0; n < 48; n++) begin
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            total++; if (a_v !== ev) $display("FAIL alt_valid cyc=%0d got=%b exp=%b", cyc, a_v, ev); else passed++;
            if (a_v === 1'b1) begin
                if (last >= 0) begin
                    total++; if (cyc - last !== R) $display("FAIL alt_period cyc=%0d got=%0d exp=%0d", cyc, cyc - last, R); else passed++;
                end
                last = cyc;
            end
            if (ev) begin
                e = sb.pop_front();
                $display("alt cyc=%0d i=%0d q=%0d", cyc, a_i, a_q);
                total++; if (a_i !== e.gi) $display("FAIL alt_i cyc=%0d got=%0d exp=%0d", cyc, a_i, e.gi); else passed++;
                total++; if (a_q !== e.gq) $display("FAIL alt_q cyc=%0d got=%0d exp=%0d", cyc, a_q, e.gq); else passed++;
            end
            drive_cycle(2);
        end
        total++; if (last !== 47) $display("FAIL alt_last_valid got=%0d exp=47", last); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        test_reset();
        test_constant();
        test_iq_separation();
        test_reset_mid();
        test_alternating();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
